// File: rtl/dsp_arb_pkg.sv
// dsp_arb_pkg: shared sizes and the result-entry type for the DSP share arbiter.
//   NUM_REQ_DEF / DATA_WIDTH_DEF : default requester count and DSP result width
//   OPW, ID_W                    : operand width and requester-id width for the defaults
//   FIFO_DEPTH, CNT_W            : result buffer depth (fixed at 2) and its occupancy width
//   resp_t                       : one buffered result {id, data}
package dsp_arb_pkg;
    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 4;
    localparam int OPW            = DATA_WIDTH_DEF / 2;
    localparam int ID_W           = $clog2(NUM_REQ_DEF);
    localparam int FIFO_DEPTH     = 2;
    localparam int CNT_W          = $clog2(FIFO_DEPTH + 1);
    typedef struct packed {
        logic [ID_W-1:0]           id;
        logic [DATA_WIDTH_DEF-1:0] data;
    } resp_t;
endpackage

// File: rtl/dsp_resp_fifo.sv
// dsp_resp_fifo: 2-entry result FIFO holding {id, data} words in grant order.
//   clk, rst_n : clock, asynchronous active-low reset (empties the buffer)
//   push_i     : write din_i at the tail
//   pop_i      : consume the head (ignored when empty)
//   dout_o     : head word, zero when empty
//   valid_o    : head word present
//   count_o    : occupancy 0..2
module dsp_resp_fifo
    import dsp_arb_pkg::*;
#(
    parameter int W = ID_W + DATA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     din_i,
    input  logic             pop_i,
    output logic [W-1:0]     dout_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);
    logic [W-1:0]     mem_q [FIFO_DEPTH];
    logic             wp_q, rp_q, do_pop;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign valid_o = cnt_q != '0;
    assign do_pop  = pop_i & valid_o;
    assign cnt_d   = cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
    assign dout_o  = valid_o ? mem_q[rp_q] : '0;
    assign count_o = cnt_q;

    // Push while full is only ever paired with a pop, so the tail slot is
    // the head being read out this cycle and may be overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (push_i) mem_q[wp_q] <= din_i;
            wp_q  <= wp_q ^ push_i;
            rp_q  <= rp_q ^ do_pop;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/dsp_share_arbiter.sv
// dsp_share_arbiter: round-robin sharing of one partially-registered DSP among NUM_REQ requesters.
//   clk, rst_n               : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  : per-requester handshake; ready is a one-hot grant
//   req_a_i, req_b_i, req_m_i: packed operands ([i*OPW +: OPW]) and mode bits
//   dsp_a_o, dsp_b_o         : granted operands (DSP registers them), zero with no grant
//   dsp_m_o                  : granted mode delayed one cycle to align with the DSP operand registers
//   dsp_out_i                : DSP result, valid the cycle after the grant
//   resp_valid_o/resp_ready_i: result handshake; resp_id_o/resp_data_o carry the FIFO head
//   stall_cnt_o              : present only with DSP_ARB_STALL_CNT_EN; saturating count of
//                              cycles where some request waits on result credit
module dsp_share_arbiter
    import dsp_arb_pkg::*;
#(
    parameter  int NUM_REQ    = NUM_REQ_DEF,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int OW         = DATA_WIDTH / 2,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*OW-1:0] req_a_i,
    input  logic [NUM_REQ*OW-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]    req_m_i,
    output logic [OW-1:0]         dsp_a_o,
    output logic [OW-1:0]         dsp_b_o,
    output logic                  dsp_m_o,
    input  logic [DATA_WIDTH-1:0] dsp_out_i,
`ifdef DSP_ARB_STALL_CNT_EN
    output logic [15:0]           stall_cnt_o,
`endif
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [IW-1:0]         resp_id_o,
    output logic [DATA_WIDTH-1:0] resp_data_o
);
    logic [IW-1:0]    rr_q, rr_d, s1_id_q, s1_id_d, gnt_idx;
    logic             s1_valid_q, s1_valid_d, s1_m_q, s1_m_d;
    logic             gnt, pop, issue_ok;
    logic [CNT_W-1:0] fifo_cnt;
    logic [2:0]       occ;

    // Results already buffered or in the DSP must fit in the FIFO after this
    // cycle's pop; otherwise a new grant could strand a result in the DSP.
    assign pop      = resp_valid_o & resp_ready_i;
    assign occ      = 3'(fifo_cnt) - 3'(pop) + 3'(s1_valid_q);
    assign issue_ok = rst_n && occ < 3'd2;

    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (issue_ok && !gnt && req_valid_i[(int'(rr_q) + k) % NUM_REQ]) begin
                gnt     = 1'b1;
                gnt_idx = IW'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready_o = gnt ? NUM_REQ'(1) << gnt_idx : '0;
    assign dsp_a_o     = gnt ? req_a_i[gnt_idx*OW +: OW] : '0;
    assign dsp_b_o     = gnt ? req_b_i[gnt_idx*OW +: OW] : '0;
    assign dsp_m_o     = s1_m_q;
    assign s1_valid_d  = gnt;
    assign s1_id_d     = gnt ? gnt_idx : '0;
    assign s1_m_d      = gnt & req_m_i[gnt_idx];
    assign rr_d        = !gnt ? rr_q : (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_m_q     <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_m_q     <= s1_m_d;
        end
    end

    dsp_resp_fifo #(.W(IW + DATA_WIDTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s1_valid_q),
        .din_i   ({s1_id_q, dsp_out_i}),
        .pop_i   (pop),
        .dout_o  ({resp_id_o, resp_data_o}),
        .valid_o (resp_valid_o),
        .count_o (fifo_cnt)
    );

`ifdef DSP_ARB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    assign stall_d     = (|req_valid_i && !issue_ok && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    assign stall_cnt_o = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end
`endif
endmodule
